// File: rtl/riscv_alu_issue_pkg.sv
// Shared encodings for the ALU issue controller: op codes, condition codes,
// FSM states and the condition-evaluation helper.
package riscv_alu_issue_pkg;

  typedef enum logic [1:0] {
    NONE = 2'b00,
    ADD  = 2'b01,
    SUB  = 2'b10,
    NAND = 2'b11
  } alu_op_e;

  localparam logic [1:0] COND_AL = 2'b00;
  localparam logic [1:0] COND_C  = 2'b01;
  localparam logic [1:0] COND_Z  = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    WB   = 2'b10
  } state_e;

  // Condition code 11 behaves like "always".
  function automatic logic cond_pass(input logic [1:0] cond, input logic c, input logic z);
    case (cond)
      COND_C:  return c;
      COND_Z:  return z;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/riscv_ex_flags.sv
// Architectural carry/zero flag registers. Each flag loads its next value
// only when its update enable is high; both clear on reset.
module riscv_ex_flags (
  input  logic clk,
  input  logic rst,
  input  logic c_we,
  input  logic c_next,
  input  logic z_we,
  input  logic z_next,
  output logic flag_c,
  output logic flag_z
);

  // Flag registers with independent update enables
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flag_c <= 1'b0;
      flag_z <= 1'b0;
    end else begin
      if (c_we) flag_c <= c_next;
      if (z_we) flag_z <= z_next;
    end
  end

endmodule

// File: rtl/riscv_alu_issue.sv
// Execute-stage issue controller in front of riscv_alu. Accepts one
// instruction, drives the ALU for a single EXEC cycle, then holds a
// writeback token until the register file takes it.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. in_ready does not depend on in_valid; wb_valid/wb_* stay
// constant while wb_ready is low.
module riscv_alu_issue
  import riscv_alu_issue_pkg::*;
#(
  parameter int RD_W   = 3,
  parameter int DATA_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [1:0]        in_op_i,
  input  logic [1:0]        in_cond_i,
  input  logic              in_cin_sel_i,
  input  logic [RD_W-1:0]   in_rd_i,
  input  logic [DATA_W-1:0] in_a_i,
  input  logic [DATA_W-1:0] in_b_i,
  output logic [1:0]        alu_op_o,
  output logic [DATA_W-1:0] alu_a_o,
  output logic [DATA_W-1:0] alu_b_o,
  output logic              alu_cin_o,
  input  logic              alu_cout_i,
  input  logic [DATA_W-1:0] alu_p_i,
  input  logic [DATA_W-1:0] compare_i,
  output logic              wb_valid_o,
  input  logic              wb_ready_i,
  output logic              wb_we_o,
  output logic [RD_W-1:0]   wb_rd_o,
  output logic [DATA_W-1:0] wb_data_o,
  output logic              flag_c_o,
  output logic              flag_z_o,
  output logic [1:0]        state_dbg
);

  state_e              state_q, state_d;
  alu_op_e             op_q;
  logic [1:0]          cond_q;
  logic                cin_sel_q;
  logic [RD_W-1:0]     rd_q;
  logic [DATA_W-1:0]   a_q, b_q;
  logic                accept;
  logic                exec_pass;
  logic                res_we;
  logic [DATA_W-1:0]   res_data;
  logic                c_we, c_next, z_we, z_next;

  assign in_ready_o = !rst_i && ((state_q == IDLE) || ((state_q == WB) && wb_ready_i));
  assign accept     = in_valid_i && in_ready_o;
  assign wb_valid_o = (state_q == WB);
  assign state_dbg  = state_q;

  // Flags seen here are the values at the start of EXEC, i.e. already
  // updated by the previous instruction.
  assign exec_pass = cond_pass(cond_q, flag_c_o, flag_z_o);

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic: EXEC always lasts one cycle; WB may accept the next
  // instruction in the same cycle the token retires.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    state_d = WB;
      WB:      if (wb_ready_i) state_d = accept ? EXEC : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Latch the instruction fields on an accepted handshake
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      op_q      <= NONE;
      cond_q    <= COND_AL;
      cin_sel_q <= 1'b0;
      rd_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
    end else if (accept) begin
      op_q      <= alu_op_e'(in_op_i);
      cond_q    <= in_cond_i;
      cin_sel_q <= in_cin_sel_i;
      rd_q      <= in_rd_i;
      a_q       <= in_a_i;
      b_q       <= in_b_i;
    end
  end

  // ALU drive: only active in EXEC; a failed condition issues NONE
  always_comb begin
    alu_op_o  = NONE;
    alu_a_o   = '0;
    alu_b_o   = '0;
    alu_cin_o = 1'b0;
    if (state_q == EXEC) begin
      alu_op_o  = exec_pass ? op_q : NONE;
      alu_a_o   = a_q;
      alu_b_o   = b_q;
      alu_cin_o = cin_sel_q & flag_c_o;
    end
  end

  // Result selection and flag updates for the instruction in EXEC
  always_comb begin
    res_we   = 1'b0;
    res_data = '0;
    c_we     = 1'b0;
    c_next   = alu_cout_i;
    z_we     = 1'b0;
    z_next   = 1'b0;
    if ((state_q == EXEC) && exec_pass) begin
      case (op_q)
        ADD: begin
          res_we   = 1'b1;
          res_data = alu_p_i;
          c_we     = 1'b1;
          z_we     = 1'b1;
          z_next   = (alu_p_i == '0);
        end
        SUB: begin
          res_data = compare_i;
          z_we     = 1'b1;
          z_next   = (compare_i == '0);
        end
        NAND: begin
          res_we   = 1'b1;
          res_data = alu_p_i;
          z_we     = 1'b1;
          z_next   = (alu_p_i == '0);
        end
        default: ;
      endcase
    end
  end

  // Capture the writeback token at the end of EXEC; held through WB
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wb_we_o   <= 1'b0;
      wb_rd_o   <= '0;
      wb_data_o <= '0;
    end else if (state_q == EXEC) begin
      wb_we_o   <= res_we;
      wb_rd_o   <= rd_q;
      wb_data_o <= res_data;
    end
  end

  riscv_ex_flags u_flags (
    .clk    (clk_i),
    .rst    (rst_i),
    .c_we   (c_we),
    .c_next (c_next),
    .z_we   (z_we),
    .z_next (z_next),
    .flag_c (flag_c_o),
    .flag_z (flag_z_o)
  );

endmodule

// File: tb/tb_riscv_alu_issue.sv
// Bench for riscv_alu_issue: behavioural ALU, instruction-level reference
// model, scoreboard queue and a negedge monitor.
module tb_riscv_alu_issue;
  import riscv_alu_issue_pkg::*;

  localparam int RD_W  = 3;
  localparam int DW    = 16;
  localparam int EXP_W = 25;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [1:0]      in_op = 2'b00, in_cond = 2'b00;
  logic            in_cin_sel = 1'b0;
  logic [RD_W-1:0] in_rd = '0;
  logic [DW-1:0]   in_a = '0, in_b = '0;
  logic [1:0]      alu_op;
  logic [DW-1:0]   alu_a, alu_b, alu_p, compare;
  logic            alu_cin, alu_cout;
  logic            wb_valid, wb_ready = 1'b0, wb_we;
  logic [RD_W-1:0] wb_rd;
  logic [DW-1:0]   wb_data;
  logic            flag_c, flag_z;
  logic [1:0]      state_dbg;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int bp_mode = 0;  // 0 random wb_ready, 1 hold low, 2 hold high

  logic [EXP_W-1:0] exp_q[$];
  int               acc_q[$];
  bit               head_seen = 0;
  logic             m_c = 0, m_z = 0;

  // clock/reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  riscv_alu_issue #(.RD_W(RD_W), .DATA_W(DW)) dut (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_op_i(in_op), .in_cond_i(in_cond), .in_cin_sel_i(in_cin_sel),
    .in_rd_i(in_rd), .in_a_i(in_a), .in_b_i(in_b),
    .alu_op_o(alu_op), .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_cin_o(alu_cin),
    .alu_cout_i(alu_cout), .alu_p_i(alu_p), .compare_i(compare),
    .wb_valid_o(wb_valid), .wb_ready_i(wb_ready), .wb_we_o(wb_we),
    .wb_rd_o(wb_rd), .wb_data_o(wb_data),
    .flag_c_o(flag_c), .flag_z_o(flag_z), .state_dbg(state_dbg)
  );

  // external ALU stand-in
  logic [DW:0] alu_sum;
  always_comb begin
    alu_sum  = {1'b0, alu_a} + {1'b0, alu_b} + {{DW{1'b0}}, alu_cin};
    alu_p    = '0;
    alu_cout = 1'b0;
    compare  = alu_a - alu_b;
    case (alu_op)
      2'b01: begin alu_p = alu_sum[DW-1:0]; alu_cout = alu_sum[DW]; end
      2'b10: alu_p = alu_a - alu_b;
      2'b11: alu_p = ~(alu_a & alu_b);
      default: ;
    endcase
  end

  // wb_ready driver, updated 2 time units after each rising edge
  always @(posedge clk) begin
    #2;
    case (bp_mode)
      1:       wb_ready = 1'b0;
      2:       wb_ready = 1'b1;
      default: wb_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference model: one instruction at a time, in acceptance order.
  // Entry: {alu_op[24:23], cin[22], we[21], rd[20:18], data[17:2], c[1], z[0]}
  task automatic model_push(input logic [1:0] op, input logic [1:0] cond, input logic cs,
                            input logic [2:0] rd, input logic [15:0] a, input logic [15:0] b);
    logic        pass, cin, we;
    logic [1:0]  eop;
    logic [15:0] data;
    int          sum;
    pass = (cond == 2'd1) ? m_c : (cond == 2'd2) ? m_z : 1'b1;
    cin  = cs & m_c;
    eop  = pass ? op : 2'd0;
    we   = 1'b0;
    data = 16'h0;
    if (pass) begin
      if (op == 2'd1) begin
        sum  = int'(a) + int'(b) + int'(cin);
        data = sum[15:0];
        we   = 1'b1;
        m_c  = (sum >= 65536);
        m_z  = (data == 0);
      end else if (op == 2'd2) begin
        data = a - b;
        m_z  = (data == 0);
      end else if (op == 2'd3) begin
        data = ~(a & b);
        we   = 1'b1;
        m_z  = (data == 0);
      end
    end
    exp_q.push_back({eop, cin, we, rd, data, m_c, m_z});
    acc_q.push_back(cyc);
  endtask

  // Driver: present an instruction and hold it until accepted
  task automatic send(input logic [1:0] op, input logic [1:0] cond, input logic cs,
                      input logic [2:0] rd, input logic [15:0] a, input logic [15:0] b,
                      output int waited);
    waited     = 0;
    in_op      = op;
    in_cond    = cond;
    in_cin_sel = cs;
    in_rd      = rd;
    in_a       = a;
    in_b       = b;
    in_valid   = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready && !rst) begin
        model_push(op, cond, cs, rd, a, b);
        @(posedge clk); #1;
        break;
      end
      waited++;
      if (waited > 50) begin
        chk("accept_timeout", 32'(waited), 0);
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", 32'(exp_q.size()), 0);
  endtask

  // scoreboard monitor
  logic             prev_hold = 1'b0;
  logic [19:0]      prev_tok = '0;
  logic [EXP_W-1:0] e;
  always @(negedge clk) begin
    if (rst) begin
      prev_hold = 1'b0;
    end else begin
      if (state_dbg == EXEC) begin
        if (exp_q.size() == 0) chk("exec_unexpected", 1, 0);
        else begin
          chk("alu_op", 32'(alu_op), 32'(exp_q[0][24:23]));
          chk("alu_cin", 32'(alu_cin), 32'(exp_q[0][22]));
        end
      end else begin
        chk("alu_idle_op", 32'(alu_op), 0);
      end
      if (wb_valid) begin
        chk("in_ready_wb", 32'(in_ready), 32'(wb_ready));
        if (prev_hold) chk("wb_stable", 32'({wb_we, wb_rd, wb_data}), 32'(prev_tok));
        if (exp_q.size() == 0) chk("wb_spurious", 1, 0);
        else begin
          if (!head_seen) begin
            chk("wb_latency", 32'(cyc), 32'(acc_q[0] + 2));
            head_seen = 1;
          end
          if (wb_ready) begin
            e = exp_q.pop_front();
            void'(acc_q.pop_front());
            head_seen = 0;
            chk("wb_we", 32'(wb_we), 32'(e[21]));
            chk("wb_rd", 32'(wb_rd), 32'(e[20:18]));
            chk("wb_data", 32'(wb_data), 32'(e[17:2]));
            chk("flag_c", 32'(flag_c), 32'(e[1]));
            chk("flag_z", 32'(flag_z), 32'(e[0]));
          end
        end
        prev_hold = !wb_ready;
        prev_tok  = {wb_we, wb_rd, wb_data};
      end else begin
        prev_hold = 1'b0;
      end
    end
  end

  initial begin
    int w;
    logic [15:0] ra, rb;
    // reset state
    #3;
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_wb_valid", 32'(wb_valid), 0);
    chk("rst_wb_tok", 32'({wb_we, wb_rd, wb_data}), 0);
    chk("rst_flags", 32'({flag_c, flag_z}), 0);
    chk("rst_alu", 32'({alu_op, alu_a, alu_b, alu_cin}), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(in_ready), 1);
    @(posedge clk); #1;

    // directed sequence
    send(2'd1, 2'd0, 1'b0, 3'd3, 16'hFFFF, 16'h0001, w);
    drain();
    chk("add_wrap_flags", 32'({flag_c, flag_z}), 32'(2'b11));
    send(2'd1, 2'd1, 1'b1, 3'd1, 16'h0010, 16'h0020, w);
    send(2'd2, 2'd0, 1'b0, 3'd2, 16'h1234, 16'h1234, w);
    send(2'd3, 2'd2, 1'b0, 3'd4, 16'hFF00, 16'h0FF0, w);
    send(2'd1, 2'd1, 1'b0, 3'd5, 16'h0001, 16'h0001, w);
    drain();
    chk("cond_fail_flags", 32'({flag_c, flag_z}), 32'(2'b00));

    // backpressure: hold wb_ready low, then release with a new instruction
    bp_mode = 1;
    send(2'd3, 2'd0, 1'b0, 3'd6, 16'h00FF, 16'h0F0F, w);
    for (int i = 0; i < 20 && !wb_valid; i++) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(wb_valid), 1);
      chk("bp_in_ready", 32'(in_ready), 0);
      @(negedge clk);
    end
    bp_mode = 2;
    @(posedge clk); #1;
    send(2'd1, 2'd0, 1'b0, 3'd7, 16'h0100, 16'h0002, w);
    chk("same_cycle_accept", 32'(w), 0);
    drain();

    // reset in the middle of EXEC
    send(2'd1, 2'd0, 1'b0, 3'd2, 16'h8000, 16'h8000, w);
    #2 rst = 1'b1;
    #1;
    exp_q.delete();
    acc_q.delete();
    head_seen = 0;
    m_c = 0;
    m_z = 0;
    chk("midrst_flags", 32'({flag_c, flag_z}), 0);
    chk("midrst_valid", 32'(wb_valid), 0);
    chk("midrst_ready", 32'(in_ready), 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_release_ready", 32'(in_ready), 1);
    chk("midrst_no_token", 32'(wb_valid), 0);
    @(posedge clk); #1;

    // randomized traffic
    bp_mode = 0;
    for (int n = 0; n < 200; n++) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      ra = 16'($urandom);
      case ($urandom_range(0, 3))
        0:       rb = ra;
        1:       rb = 16'(-ra);
        default: rb = 16'($urandom);
      endcase
      send(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           3'($urandom_range(0, 7)), ra, rb, w);
    end
    drain();
    repeat (3) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
